// File: rtl/cdd_pkg.sv
// Shared constants and types for the CD sector framer and its descrambler.
package cdd_pkg;
  localparam int          SECTOR_WORDS = 1176;
  localparam int          BODY_START   = 6;
  localparam logic [14:0] LFSR_SEED    = 15'h0001;

  // Element 5 is the oldest word, matching the delay-line ordering.
  localparam logic [5:0][15:0] SYNC_PAT = {16'h00FF, 16'hFFFF, 16'hFFFF,
                                           16'hFFFF, 16'hFFFF, 16'hFF00};

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;
  typedef logic [5:0][15:0] dline_t;
endpackage

// File: rtl/cdd_descrambler.sv
// CD-ROM scrambler stream: 15-bit LFSR advanced 16 bits per body word.
// Mask bits are LSB-first per byte, high byte first.
module cdd_descrambler
  import cdd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  output logic [15:0] mask
);
  logic [14:0] lfsr;
  logic [14:0] lfsr_nxt;
  logic [15:0] stream;

  // stream[i] holds the bit produced on step i of this word.
  always_comb begin
    lfsr_nxt = lfsr;
    stream   = '0;
    for (int i = 0; i < 16; i++) begin
      stream   = {lfsr_nxt[0], stream[15:1]};
      lfsr_nxt = {lfsr_nxt[0] ^ lfsr_nxt[1], lfsr_nxt[14:1]};
    end
    mask = {stream[7:0], stream[15:8]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (load) begin
      lfsr <= LFSR_SEED;
    end else if (step) begin
      lfsr <= lfsr_nxt;
    end
  end
endmodule

// File: rtl/cdd_sector_framer.sv
// Sync hunt, flywheel lock and descramble of CD-ROM sectors into 1176-word
// strobed output; reports header, lock status and lock-loss count.
module cdd_sector_framer
  import cdd_pkg::*;
#(
  parameter int MISS_MAX = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] din,
  input  logic        din_valid,
  input  logic        resync,
  input  logic        descr_en,
  output logic [15:0] cd_d,
  output logic        cd_ck,
  output logic        sector_start,
  output logic        sector_done,
  output logic [31:0] header,
  output logic        sync_lock,
  output logic [7:0]  lost_cnt
);
  localparam logic [10:0] LAST_WORD = 11'(SECTOR_WORDS - 1);
  localparam logic [10:0] BODY_W    = 11'(BODY_START);

  state_t      state, state_nxt;
  dline_t      dl, dl_shift;
  logic [10:0] wcnt, wcnt_nxt;
  logic [1:0]  miss, miss_nxt;
  logic [2:0]  miss_inc;
  logic        match, emit, lost_inc, body;
  logic [15:0] mask, out_word;

  assign dl_shift  = {dl[4:0], din};
  assign match     = (dl_shift == SYNC_PAT);
  assign miss_inc  = {1'b0, miss} + 3'd1;
  assign body      = (wcnt >= BODY_W);
  assign out_word  = dl[5] ^ ((descr_en && body) ? mask : 16'h0000);
  assign sync_lock = (state == LOCK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    miss_nxt  = miss;
    emit      = 1'b0;
    lost_inc  = 1'b0;
    if (resync) begin
      state_nxt = HUNT;
      miss_nxt  = '0;
      wcnt_nxt  = '0;
    end else if (din_valid) begin
      case (state)
        HUNT: begin
          if (match) begin
            state_nxt = LOCK;
            wcnt_nxt  = '0;
            miss_nxt  = '0;
          end
        end
        LOCK: begin
          emit = 1'b1;
          if (wcnt == LAST_WORD) begin
            // Flywheel: the next sector starts here whether or not sync matched.
            wcnt_nxt = '0;
            if (match) begin
              miss_nxt = '0;
            end else if (int'(miss_inc) >= MISS_MAX) begin
              state_nxt = HUNT;
              miss_nxt  = '0;
              lost_inc  = 1'b1;
            end else begin
              miss_nxt = miss_inc[1:0];
            end
          end else begin
            wcnt_nxt = wcnt + 11'd1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  cdd_descrambler u_descr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (emit && !body),
    .step  (emit && body),
    .mask  (mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl           <= '0;
      wcnt         <= '0;
      miss         <= '0;
      cd_d         <= '0;
      cd_ck        <= 1'b0;
      sector_start <= 1'b0;
      sector_done  <= 1'b0;
      header       <= '0;
      lost_cnt     <= '0;
    end else begin
      if (din_valid) dl <= dl_shift;
      wcnt         <= wcnt_nxt;
      miss         <= miss_nxt;
      cd_ck        <= emit;
      sector_start <= emit && (wcnt == 11'd0);
      sector_done  <= emit && (wcnt == LAST_WORD);
      if (emit) cd_d <= out_word;
      if (emit && wcnt == 11'd6) header[31:16] <= out_word;
      if (emit && wcnt == 11'd7) header[15:0]  <= out_word;
      if (lost_inc && lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_cdd_sector_framer.sv
// Directed bench for cdd_sector_framer: table-driven lock-in sequence plus
// hand-written sectors for header, flywheel loss, resync and raw mode.
module tb_cdd_sector_framer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        resync = 1'b0;
  logic        descr_en = 1'b1;
  logic [15:0] cd_d;
  logic        cd_ck;
  logic        sector_start;
  logic        sector_done;
  logic [31:0] header;
  logic        sync_lock;
  logic [7:0]  lost_cnt;

  cdd_sector_framer #(.MISS_MAX(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .din_valid    (din_valid),
    .resync       (resync),
    .descr_en     (descr_en),
    .cd_d         (cd_d),
    .cd_ck        (cd_ck),
    .sector_start (sector_start),
    .sector_done  (sector_done),
    .header       (header),
    .sync_lock    (sync_lock),
    .lost_cnt     (lost_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic        exp_ck;
    logic [15:0] exp_d;
    logic        exp_start;
    logic        exp_lock;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sync_tb [6];
  logic [15:0] exp_mask [1176];
  logic [15:0] emq [$];
  int          starts, dones;
  logic        o_ck, o_start, o_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One input word, two clocks; outputs sampled on the following falling edge.
  task automatic send(input logic [15:0] w, input logic rs);
    @(negedge clk);
    din = w; din_valid = 1'b1; resync = rs;
    @(negedge clk);
    din_valid = 1'b0; resync = 1'b0;
    o_ck = cd_ck; o_start = sector_start; o_done = sector_done;
    if (cd_ck) emq.push_back(cd_d);
    if (sector_start) starts++;
    if (sector_done) dones++;
  endtask

  task automatic feed_sector(input logic [15:0] w6, input logic [15:0] w7, input logic good);
    for (int i = 0; i < 1170; i++)
      send((i == 0) ? w6 : (i == 1) ? w7 : 16'h0000, 1'b0);
    for (int i = 0; i < 6; i++)
      send((i == 5 && !good) ? 16'hFF01 : sync_tb[i], 1'b0);
  endtask

  initial begin
    vec_t        tbl [14];
    logic [14:0] r;
    logic [7:0]  b;
    logic [15:0] m;
    logic [31:0] acc;
    int          bad;

    sync_tb = '{16'h00FF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFF00};
    for (int i = 0; i < 6; i++)
      tbl[i] = '{din: sync_tb[i], exp_ck: 1'b0, exp_d: 16'h0000, exp_start: 1'b0, exp_lock: (i == 5)};
    for (int i = 0; i < 6; i++)
      tbl[6+i] = '{din: 16'h0000, exp_ck: 1'b1, exp_d: sync_tb[i], exp_start: (i == 0), exp_lock: 1'b1};
    tbl[12] = '{din: 16'h0000, exp_ck: 1'b1, exp_d: 16'h0180, exp_start: 1'b0, exp_lock: 1'b1};
    tbl[13] = '{din: 16'h0000, exp_ck: 1'b1, exp_d: 16'h0060, exp_start: 1'b0, exp_lock: 1'b1};

    // Scrambler reference: bytes built bit by bit, high byte first.
    r = 15'h0001;
    for (int w = 0; w < 1176; w++) exp_mask[w] = 16'h0000;
    for (int w = 6; w < 1176; w++) begin
      m = '0;
      for (int by = 0; by < 2; by++) begin
        b = '0;
        for (int bt = 0; bt < 8; bt++) begin
          b = b | (8'(r[0]) << bt);
          r = {r[0] ^ r[1], r[14:1]};
        end
        m = (by == 0) ? {b, 8'h00} : (m | {8'h00, b});
      end
      exp_mask[w] = m;
    end

    // Reset state
    #12;
    chk("rst_cd_d", {16'h0, cd_d}, 32'h0);
    chk("rst_strobes", {29'h0, cd_ck, sector_start, sector_done}, 32'h0);
    chk("rst_header", header, 32'h0);
    chk("rst_lock_lost", {23'h0, sync_lock, lost_cnt}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    acc = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = acc | {16'h0, cd_d} | header | {23'h0, sync_lock, lost_cnt}
                | {29'h0, cd_ck, sector_start, sector_done};
    end
    chk("idle_outputs", acc, 32'h0);

    // Sector A: lock-in via table, then zero body with descrambling.
    emq.delete(); starts = 0; dones = 0;
    for (int i = 0; i < 14; i++) begin
      send(tbl[i].din, 1'b0);
      chk($sformatf("tbl%0d_ck", i), {31'h0, o_ck}, {31'h0, tbl[i].exp_ck});
      chk($sformatf("tbl%0d_d", i), {16'h0, cd_d}, {16'h0, tbl[i].exp_d});
      chk($sformatf("tbl%0d_start", i), {31'h0, o_start}, {31'h0, tbl[i].exp_start});
      chk($sformatf("tbl%0d_lock", i), {31'h0, sync_lock}, {31'h0, tbl[i].exp_lock});
    end
    for (int i = 0; i < 1162; i++) send(16'h0000, 1'b0);
    for (int i = 0; i < 6; i++) send(sync_tb[i], 1'b0);
    chk("a_done_last", {30'h0, o_ck, o_done}, 32'h3);
    chk("a_count", emq.size(), 1176);
    chk("a_starts_dones", {starts[15:0], dones[15:0]}, {16'd1, 16'd1});
    bad = 0;
    for (int w = 0; w < emq.size() && w < 1176; w++)
      if (emq[w] !== (((w < 6) ? sync_tb[w] : 16'h0000) ^ exp_mask[w])) bad++;
    chk("a_word_errs", bad, 0);
    chk("a_lock", {31'h0, sync_lock}, 32'h1);

    // Sector B: header through descrambler.
    emq.delete();
    feed_sector(16'h0082, 16'h1661, 1'b1);
    chk("b_header", header, 32'h01021601);
    chk("b_w6w7", (emq.size() == 1176) ? {emq[6], emq[7]} : 32'hDEAD, 32'h01021601);

    // Flywheel: first missing sync tolerated, second drops lock.
    emq.delete(); starts = 0; dones = 0;
    feed_sector(16'h0000, 16'h0000, 1'b0);
    chk("c1_lock_held", {31'h0, sync_lock}, 32'h1);
    chk("c1_lost", {24'h0, lost_cnt}, 32'h0);
    emq.delete(); starts = 0; dones = 0;
    feed_sector(16'h0000, 16'h0000, 1'b0);
    chk("c2_flywheel_count", emq.size(), 1176);
    chk("c2_starts_dones", {starts[15:0], dones[15:0]}, {16'd1, 16'd1});
    chk("c2_final_emit", {30'h0, o_ck, o_done}, 32'h3);
    chk("c2_lock_dropped", {31'h0, sync_lock}, 32'h0);
    chk("c2_lost", {24'h0, lost_cnt}, 32'h1);

    // Resync in mid-sector, then relock.
    for (int i = 0; i < 6; i++) send(sync_tb[i], 1'b0);
    chk("d_relock", {31'h0, sync_lock}, 32'h1);
    for (int i = 0; i < 10; i++) send(16'h5555, 1'b0);
    send(16'h1111, 1'b1);
    chk("d_resync_no_ck", {31'h0, o_ck}, 32'h0);
    chk("d_resync_hunt", {31'h0, sync_lock}, 32'h0);
    emq.delete();
    for (int i = 0; i < 5; i++) send(sync_tb[i], 1'b0);
    send(sync_tb[5], 1'b1);
    chk("d_match_ignored", {31'h0, sync_lock}, 32'h0);
    for (int i = 0; i < 6; i++) send(sync_tb[i], 1'b0);
    chk("d_lock_again", {31'h0, sync_lock}, 32'h1);
    chk("d_no_emit_in_hunt", emq.size(), 0);
    send(16'h1234, 1'b0);
    chk("d_word0", {14'h0, o_ck, o_start, cd_d}, {14'h0, 1'b1, 1'b1, 16'h00FF});

    // Raw mode: words 1..5 unchanged, body words pass through.
    descr_en = 1'b0;
    for (int i = 1; i < 6; i++) begin
      send((i == 1) ? 16'hABCD : 16'h0000, 1'b0);
      chk($sformatf("e_word%0d", i), {16'h0, cd_d}, {16'h0, sync_tb[i]});
    end
    send(16'h0000, 1'b0);
    chk("e_word6_raw", {16'h0, cd_d}, 32'h1234);
    send(16'h0000, 1'b0);
    chk("e_word7_raw", {16'h0, cd_d}, 32'hABCD);
    chk("e_header_raw", header, 32'h1234ABCD);

    // Asynchronous reset in mid-sector.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("r_cleared", {cd_d, 5'h0, cd_ck, sector_start, sector_done, sync_lock, lost_cnt}, 32'h0);
    chk("r_header", header, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    send(16'h0000, 1'b0);
    chk("r_no_strobe", {29'h0, o_ck, o_start, sync_lock}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
